// File: rtl/stack_pkg.sv
// Shared definitions for the scratch data stack controller: opcodes, FSM states
// and default geometry.
package stack_pkg;

   localparam int unsigned STACK_AW = 8;
   localparam int unsigned STACK_DW = 32;

   localparam logic [1:0] OP_PUSH    = 2'b00;
   localparam logic [1:0] OP_POP     = 2'b01;
   localparam logic [1:0] OP_REPLACE = 2'b10;
   localparam logic [1:0] OP_DUP     = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WR      = 2'd1,
      ST_RD_ADDR = 2'd2,
      ST_RD_CAP  = 2'd3
   } state_e;

   // True for the opcodes that grow the stack by one cell.
   function automatic logic op_grows(input logic [1:0] op);
      return (op == OP_PUSH) || (op == OP_DUP);
   endfunction

endpackage

// File: rtl/scratch_stack_ctrl.sv
// Scratch data stack sequencer: TOS lives in a register and older cells are
// spilled to / refilled from an external single-port RAM with registered read.
module scratch_stack_ctrl
   import stack_pkg::*;
#(
   parameter int unsigned AW = STACK_AW,
   parameter int unsigned DW = STACK_DW
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [DW-1:0] cmd_data,
   output logic [DW-1:0] tos,
   output logic          tos_valid,
   output logic [AW:0]   depth,
   output logic          full,
   output logic          err_overflow,
   output logic          err_underflow,
   input  logic          err_clr,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   output logic          ram_wen,
   input  logic [DW-1:0] ram_rdata
);

   localparam logic [AW:0] CAPACITY = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] SP_ONE   = {{AW{1'b0}}, 1'b1};

   state_e        state_q, state_d;
   logic [AW:0]   sp_q, sp_d;
   logic [DW-1:0] tos_q, tos_d;
   logic          tos_valid_q, tos_valid_d;
   logic [AW-1:0] ram_addr_q, ram_addr_d;
   logic [DW-1:0] ram_wdata_q, ram_wdata_d;
   logic          ram_wen_q, ram_wen_d;
   logic          err_ovf_q, err_ovf_d;
   logic          err_unf_q, err_unf_d;

   logic          set_ovf;
   logic          set_unf;
   logic [AW:0]   depth_w;
   logic          full_w;
   logic [AW:0]   sp_dec;
   logic [DW-1:0] push_val;

   assign depth_w  = sp_q + {{AW{1'b0}}, tos_valid_q};
   assign full_w   = (depth_w == CAPACITY);
   assign sp_dec   = sp_q - SP_ONE;
   // DUP is a PUSH of the current TOS, so both share one datapath.
   assign push_val = (cmd_op == OP_DUP) ? tos_q : cmd_data;

   always_comb begin
      state_d     = state_q;
      sp_d        = sp_q;
      tos_d       = tos_q;
      tos_valid_d = tos_valid_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      ram_wen_d   = 1'b0;
      set_ovf     = 1'b0;
      set_unf     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               if (op_grows(cmd_op)) begin
                  if ((cmd_op == OP_DUP) && !tos_valid_q) begin
                     set_unf = 1'b1;
                  end else if (full_w) begin
                     set_ovf = 1'b1;
                  end else if (!tos_valid_q) begin
                     tos_d       = push_val;
                     tos_valid_d = 1'b1;
                  end else begin
                     ram_addr_d  = sp_q[AW-1:0];
                     ram_wdata_d = tos_q;
                     ram_wen_d   = 1'b1;
                     sp_d        = sp_q + SP_ONE;
                     tos_d       = push_val;
                     state_d     = ST_WR;
                  end
               end else if (cmd_op == OP_POP) begin
                  if (!tos_valid_q) begin
                     set_unf = 1'b1;
                  end else if (sp_q == '0) begin
                     tos_valid_d = 1'b0;
                  end else begin
                     ram_addr_d = sp_dec[AW-1:0];
                     sp_d       = sp_dec;
                     state_d    = ST_RD_ADDR;
                  end
               end else begin
                  // REPLACE on an empty stack lands in the same place as PUSH.
                  tos_d       = cmd_data;
                  tos_valid_d = 1'b1;
               end
            end
         end
         ST_WR: begin
            state_d = ST_IDLE;
         end
         ST_RD_ADDR: begin
            // RAM captures mem[ram_addr] on this edge; data is usable next cycle.
            state_d = ST_RD_CAP;
         end
         ST_RD_CAP: begin
            tos_d   = ram_rdata;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A new error in the same cycle as err_clr must survive.
      err_ovf_d = (err_ovf_q & ~err_clr) | set_ovf;
      err_unf_d = (err_unf_q & ~err_clr) | set_unf;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         sp_q        <= '0;
         tos_q       <= '0;
         tos_valid_q <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         ram_wen_q   <= 1'b0;
         err_ovf_q   <= 1'b0;
         err_unf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sp_q        <= sp_d;
         tos_q       <= tos_d;
         tos_valid_q <= tos_valid_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ram_wen_q   <= ram_wen_d;
         err_ovf_q   <= err_ovf_d;
         err_unf_q   <= err_unf_d;
      end
   end

   assign cmd_ready     = (state_q == ST_IDLE);
   assign tos           = tos_q;
   assign tos_valid     = tos_valid_q;
   assign depth         = depth_w;
   assign full          = full_w;
   assign err_overflow  = err_ovf_q;
   assign err_underflow = err_unf_q;
   assign ram_addr      = ram_addr_q;
   assign ram_wdata     = ram_wdata_q;
   assign ram_wen       = ram_wen_q;

endmodule

// File: doc/scratch_stack_ctrl.md
Name: scratch_stack_ctrl

Overview:
- Sequences the 32-bit scratch data stack. Holds the top-of-stack (TOS) in a register and spills older cells to the external single-port 8-bit-address stack RAM, whose read output is registered.
- Presents a command handshake (PUSH/POP/REPLACE/DUP) to the CPU core and owns the RAM address, write data and write enable.
- Replaces the CPU's ad-hoc stack phases 3/4/41/42/5 and tracks depth and over/underflow.

Parameters:
- AW, 8, RAM address width; RAM holds 2**AW cells.
- DW, 32, cell width.

Ports:
- clk  in  1  system clock (16 MHz)
- resetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  controller idle; command accepted when cmd_valid && cmd_ready at posedge
- cmd_op  in  2  00 PUSH, 01 POP, 10 REPLACE, 11 DUP
- cmd_data  in  DW  value for PUSH/REPLACE
- tos  out  DW  current top-of-stack value
- tos_valid  out  1  stack non-empty
- depth  out  AW+1  cells held, including TOS (0..2**AW)
- full  out  1  depth == 2**AW
- err_overflow  out  1  sticky: PUSH/DUP attempted while full
- err_underflow  out  1  sticky: POP/DUP attempted while empty
- err_clr  in  1  clears both sticky errors
- ram_addr  out  AW  to stack RAM addr
- ram_wdata  out  DW  to stack RAM din
- ram_wen  out  1  to stack RAM write_en
- ram_rdata  in  DW  from stack RAM dout; valid one clk after ram_addr is presented

Behaviour:
- Reset (asynchronous, resetn low), all outputs and state cleared:
  - state=IDLE, sp=0 (spilled cells), tos=0, tos_valid=0.
  - ram_wen=0, ram_addr=0, ram_wdata=0.
  - Both errors 0, cmd_ready=1.
  - Reset mid-operation abandons the operation; RAM contents are ignored because sp=0.
- depth = sp + tos_valid. full = (depth == 2**AW).
- cmd_ready = (state == IDLE). All outputs are registered or decoded directly from registers.
- States: IDLE, WR, RD_ADDR, RD_CAP.
- PUSH, accepted in IDLE:
  - full: no state change, err_overflow<=1; cmd_ready stays 1.
  - tos_valid=0: tos<=cmd_data, tos_valid<=1; stays IDLE (1 cycle).
  - else: ram_addr<=sp[AW-1:0], ram_wdata<=tos, ram_wen<=1, sp<=sp+1, tos<=cmd_data; go WR.
- WR: ram_wen<=0; go IDLE. Push with spill occupies 2 cycles, so cmd_ready is low for exactly 1 cycle.
- POP, accepted in IDLE:
  - tos_valid=0: err_underflow<=1; no change.
  - sp=0: tos_valid<=0, tos unchanged; 1 cycle.
  - else: ram_addr<=sp-1, sp<=sp-1; go RD_ADDR.
- RD_ADDR: RAM registers mem[ram_addr] at this edge; go RD_CAP.
- RD_CAP: tos<=ram_rdata; go IDLE. Pop with refill occupies 3 cycles; tos is updated when cmd_ready returns high.
- REPLACE:
  - tos_valid=1: tos<=cmd_data; 1 cycle.
  - empty: behaves as PUSH on empty (tos_valid<=1).
- DUP: identical to PUSH with cmd_data replaced by current tos.
  - empty: err_underflow<=1.
  - full: err_overflow<=1.
- ram_wen is asserted only in the cycle after a spill accept. It is never high in RD_* states.
- Errors:
  - Sticky until err_clr.
  - err_clr in the same cycle as a new error: the error is set (set wins).
  - Erroring commands are still accepted (handshake completes) with no stack change.
- Width rules:
  - sp is AW+1 bits; maximum sp is 2**AW-1 because TOS occupies one slot at full.
  - ram_addr = sp[AW-1:0]. No wrap-around is possible by construction.
- cmd_data and cmd_op are sampled only at the accept edge. They need not be held afterwards.

Decomposition:
- Shared package stack_pkg:
  - opcode constants OP_PUSH=2'b00, OP_POP=2'b01, OP_REPLACE=2'b10, OP_DUP=2'b11.
  - state encoding ST_IDLE/ST_WR/ST_RD_ADDR/ST_RD_CAP.
  - default AW/DW.
- No sub-module: the stack RAM (existing ram block, via cellram_scratch) stays outside and is wired to the ram_* ports in top.
- Bench instantiates the same RAM model.

Test Plan:
- Reset then PUSH 0x11: 1 cycle busy-free. tos=0x11, depth=1, ram_wen never asserted.
- PUSH 0x11, 0x22, 0x33 back-to-back, holding cmd_valid:
  - cmd_ready low 1 cycle after the 2nd and 3rd accepts.
  - RAM[0]=0x11, RAM[1]=0x22; tos=0x33, depth=3.
- Then POP, POP:
  - tos=0x22 three cycles after the 1st accept, then tos=0x11.
  - depth=1; ram_addr=1 then 0; ram_wen=0 throughout.
- POP at depth=1 -> tos_valid=0, depth=0. Another POP -> err_underflow=1, depth stays 0. err_clr -> 0. err_clr together with POP on empty -> err_underflow stays 1.
- Fill 256 cells (AW=8) -> full=1, depth=256. PUSH 0xDEAD -> err_overflow=1, tos unchanged. DUP -> same. POP -> tos equals the 255th pushed value.
- Assert resetn low in RD_ADDR mid-POP -> all outputs at reset values immediately (async). After release, PUSH 0x5 -> tos=0x5, depth=1.
